day20_arb: RTL
==============

# day20_arb

Round-robin arbiter that shares the single day20 memory read/write port between up to NUM_REQ requesters. It accepts one command at a time, drives it onto the memory port and holds it there until the memory accepts it. For reads it waits for the returned data and routes it back to the owning requester. It sits between the requester blocks and the memory, and is the only master on the memory port.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 8: memory address width.
- TIMEOUT, 16: cycles to wait for read data before aborting, ≥2.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state and outputs.
- req_i  in  NUM_REQ  per-requester request; held high until that requester's gnt_o.
- we_i  in  NUM_REQ  per-requester op: 1 write, 0 read.
- addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_REQ*32  packed write data; requester k at [k*32 +: 32].
- gnt_o  out  NUM_REQ  one-hot, 1-cycle pulse; command accepted by memory.
- done_o  out  NUM_REQ  one-hot, 1-cycle pulse; transaction complete.
- rd_data_o  out  32  read data; valid in the done_o cycle of a read.
- err_o  out  1  1-cycle pulse with done_o when a read timed out.
- mem_req_o  out  1  command valid to memory.
- mem_we_o  out  1  command op.
- mem_addr_o  out  ADDR_W  command address.
- mem_wdata_o  out  32  command write data.
- mem_ready_i  in  1  memory accepts the command this cycle.
- mem_rd_valid_i  in  1  read data return strobe.
- mem_rd_data_i  in  32  read data.

## Operation
- All outputs are registered. Reset value of every output is 0. The state machine resets to IDLE, the priority pointer to 0 and the timeout counter to 0.
- IDLE:
  - Eligible set = req_i & ~gnt_o. This masks a requester that is being granted in the current cycle.
  - If the set is non-empty, pick the first eligible index scanning upward from ptr and wrapping mod NUM_REQ.
  - Latch that requester's index, we, addr and wdata into mem_*_o, set mem_req_o=1, and go to ISSUE.
- ISSUE:
  - mem_req_o and the command stay stable until mem_ready_i=1.
  - On accept: clear mem_req_o, pulse gnt_o[idx], and set ptr = (idx+1) mod NUM_REQ.
  - Write: pulse done_o[idx] in the same cycle as gnt_o, then go to IDLE.
  - Read: go to WAIT_RD with the counter cleared.
- WAIT_RD:
  - On mem_rd_valid_i: rd_data_o <= mem_rd_data_i, pulse done_o[idx], then go to IDLE.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT-1 with no valid: rd_data_o <= 32'hDEAD_BEEF, pulse done_o[idx] and err_o, then go to IDLE.
  - If valid arrives in the same cycle as the timeout, valid wins and err_o stays 0.
- mem_rd_valid_i outside WAIT_RD is ignored.
- Changes to a requester's addr/wdata/we after latching are ignored.
- rd_data_o holds its value between reads.
- Reset asserted mid-transaction abandons the transaction: no gnt_o or done_o for it after release.

## Timing
- Request sampled in IDLE at cycle 0 → mem_req_o high in cycle 1.
- mem_ready_i high in cycle n → gnt_o (and done_o for a write) high in cycle n+1. The arbiter is back in IDLE in cycle n+1.
- Best case is one accepted command every 2 cycles.
- Read: mem_rd_valid_i in cycle m → done_o and rd_data_o in cycle m+1.
- Read with no return: done_o and err_o in cycle n+1+TIMEOUT.

## Test plan
- Single write: req_i=0001, we=1, addr 0x10, wdata 0xA5A5_0001, mem_ready_i tied high.
  - Cycle 1: mem_req_o=1, mem_we_o=1, mem_addr_o=0x10, mem_wdata_o=0xA5A5_0001.
  - Cycle 2: gnt_o=done_o=0001 for exactly one cycle, mem_req_o=0.
- Single read: requester 1 reads addr 0x22; mem_rd_valid_i arrives 3 cycles after accept with 0x1234_5678.
  - gnt_o=0010 one cycle after accept.
  - done_o=0010 and rd_data_o=0x1234_5678 one cycle after valid; err_o stays 0.
- Round robin: all four requesters hold write requests and re-raise req_i after each grant; mem_ready_i=1.
  - Grants are 0,1,2,3,0,1, spaced 2 cycles apart.
  - No requester is granted twice before the others.
- Backpressure: mem_ready_i=0 for 5 cycles after mem_req_o rises, while requesters 2 and 3 toggle addr_i.
  - Command stays identical for all 5 cycles; no gnt_o.
  - Grant follows the cycle after mem_ready_i=1.
- Timeout: TIMEOUT=16; read accepted, mem_rd_valid_i never asserted.
  - Exactly 16 cycles after the gnt_o cycle: done_o and err_o pulse, rd_data_o=0xDEAD_BEEF.
  - Next request is served normally.
- Reset mid-read: reset driven low during WAIT_RD.
  - All outputs go to 0 immediately.
  - After release, a stray mem_rd_valid_i produces no done_o.
  - Next request from requesters 0 and 2 grants 0 first (ptr=0).

Source files
------------

// File: rtl/day20_arb.sv
// rtl/day20_arb.sv - round-robin arbiter sharing the day20 memory port between NUM_REQ requesters
module day20_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*32-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [31:0]               rd_data_o,
  output logic                      err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_rd_valid_i,
  input  logic [31:0]               mem_rd_data_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW:0]   NUM_W    = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [31:0]         wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  elig;
  logic                found;
  logic [IW-1:0]       sel_idx;
  logic [IW:0]         sum;
  logic [IW-1:0]       cand;
  logic [NUM_REQ-1:0]  idx_onehot;
  logic [IW-1:0]       ptr_next;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = wdata_i[k*32 +: 32];
  end

  // A requester whose grant pulse is on the output right now still has req_i high; skip it.
  always_comb begin
    elig    = req_i & ~gnt_o;
    found   = 1'b0;
    sel_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NUM_W) begin
        sum = sum - NUM_W;
      end
      cand = sum[IW-1:0];
      if (!found && elig[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign idx_onehot = NUM_REQ'(1) << idx;
  assign ptr_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      idx         <= '0;
      cnt         <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      err_o       <= 1'b0;
      rd_data_o   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      gnt_o  <= '0;
      done_o <= '0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            idx         <= sel_idx;
            mem_req_o   <= 1'b1;
            mem_we_o    <= we_i[sel_idx];
            mem_addr_o  <= addr_arr[sel_idx];
            mem_wdata_o <= wdata_arr[sel_idx];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            gnt_o     <= idx_onehot;
            ptr       <= ptr_next;
            if (mem_we_o) begin
              done_o <= idx_onehot;
              state  <= IDLE;
            end else begin
              cnt   <= '0;
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // Returned data takes precedence over a timeout landing in the same cycle.
          if (mem_rd_valid_i) begin
            rd_data_o <= mem_rd_data_i;
            done_o    <= idx_onehot;
            state     <= IDLE;
          end else if (cnt == CNT_LAST) begin
            rd_data_o <= 32'hDEAD_BEEF;
            done_o    <= idx_onehot;
            err_o     <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
